fnd_scan_ctrl: RTL
==================

FND_SCAN_CTRL -- requirements
Module: fnd_scan_ctrl

Interface
REQ-001 Parameter SCAN_DIV, default 100_000: PCLK cycles per digit slot (1 kHz scan at 100 MHz).
REQ-002 Parameter BLANK_CYC, default 16: cycles at the start of each slot with every common driven off (anti-ghosting).
REQ-003 Parameter BLINK_SLOTS, default 500: digit slots per blink half-period.
REQ-004 PCLK  input  1  single clock; all logic on rising edge.
REQ-005 PRESET  input  1  reset, synchronous and active-high.
REQ-006 value  input  14  binary value to display; sampled only when load=1.
REQ-007 load  input  1  single-cycle request to convert and display value.
REQ-008 digit_en  input  4  per-digit enable; bit i=0 blanks digit i (bit 0 = ones).
REQ-009 dp  input  4  per-digit decimal point, active-high.
REQ-010 lz_en  input  1  1 = suppress leading zeros.
REQ-011 blink_en  input  1  1 = whole display blinks.
REQ-012 fnd_data  output  8  segments, active-low, bit 7 = dp.
REQ-013 fnd_com  output  4  digit commons, active-low, one-hot-zero.
REQ-014 busy  output  1  conversion in progress or pending.
REQ-015 sat  output  1  sticky: last committed value exceeded 9999.

Function
REQ-016 Conversion FSM SHALL have states IDLE, CONV, COMMIT.
REQ-017 IDLE with load=1: capture min(value, 9999) and set sat_next = (value>9999); go to CONV.
REQ-018 CONV: one shift-add-3 (double-dabble) iteration per cycle, exactly 14 cycles, then COMMIT.
REQ-019 COMMIT (1 cycle): write the four BCD digit registers and sat atomically; go to CONV if a pending value exists, else IDLE.
REQ-020 busy SHALL be 1 in CONV and COMMIT and while the pending slot is full; load sampled at edge k from IDLE yields digit registers updated at edge k+15.
REQ-021 load while in CONV or COMMIT SHALL write the one-deep pending slot; a later load overwrites it (last value wins); no load is ever dropped except by overwrite.
REQ-022 Displayed digits SHALL never show a partially converted value.
REQ-023 Slot counter counts 0..SCAN_DIV-1; at wrap, digit index advances 0->1->2->3->0.
REQ-024 While slot counter < BLANK_CYC, fnd_com SHALL be 4'hF.
REQ-025 Otherwise fnd_com SHALL drive ~(1<<idx), unless blanked per REQ-026..028, in which case 4'hF.
REQ-026 Digit idx blanked when digit_en[idx]=0.
REQ-027 With lz_en=1, digit idx>0 blanked when it and all higher digits are 0; digit 0 never blanked by lz_en.
REQ-028 Blink: phase toggles every BLINK_SLOTS slots; with blink_en=1 and phase=off, all digits blanked; blink_en=0 forces phase=on and holds the phase counter at 0.
REQ-029 fnd_data[6:0] SHALL use the common-anode table 0:C0 1:F9 2:A4 3:B0 4:99 5:92 6:82 7:F8 8:80 9:90 (low 7 bits); fnd_data[7] = ~dp[idx]; blanked digits drive 8'hFF.
REQ-030 fnd_data and fnd_com SHALL be registered: one cycle latency from slot/index/digit state.

Reset
REQ-031 PRESET=1 at an edge: FSM=IDLE, pending cleared, digit registers 0, sat=0, busy=0, slot counter 0, idx 0, blink phase on, fnd_com=4'hF, fnd_data=8'hFF.
REQ-032 Reset mid-conversion SHALL abandon it; no COMMIT occurs; a simultaneous load is ignored.

Structure
REQ-033 Package fnd_pkg SHALL hold the FSM state enum, the 10-entry segment constant table, and the BCD digit typedef (logic [3:0]).
REQ-034 The iterative converter SHALL be one sub-module fnd_bin2bcd_seq (start, 14-bit in, done, 16-bit BCD out); scan, blink and output logic stay in the top.

Verification (bench params SCAN_DIV=10, BLANK_CYC=2, BLINK_SLOTS=4)
REQ-035 Reset, then load value=1234 -> busy high 15 cycles; digits 4,3,2,1 on idx 0..3; fnd_data 99,B0,A4,F9 with fnd_com E,D,B,7 after 2 blank cycles per slot.
REQ-036 load=12000 -> digits show 9999 (90 x4), sat=1; then load=5 -> sat=0.
REQ-037 load 1111, then 2222 at +3 cycles and 3333 at +5 cycles -> display goes 1111 then 3333; 2222 never committed; busy low after 31 cycles.
REQ-038 value=7, lz_en=1, dp=4'b0001 -> only idx 0 lit with fnd_data=8'h78; idx 1..3 fnd_com=F.
REQ-039 blink_en=1 -> all commons F for 4 consecutive slots, lit for next 4; digit_en=4'b1010 blanks idx 0 and 2.
REQ-040 PRESET asserted 5 cycles into a conversion of 4321 -> outputs at reset values, digits remain 0, busy=0, no later commit.

Source files
------------

// File: rtl/fnd_pkg.sv
// Shared types and constants for the FND scan controller: conversion FSM states,
// BCD digit type and the common-anode segment table.
package fnd_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_CONV   = 2'd1,
    ST_COMMIT = 2'd2
  } conv_state_t;

  typedef logic [3:0] bcd_digit_t;

  localparam int unsigned BIN_W      = 14;
  localparam int unsigned CONV_STEPS = 14;
  localparam logic [13:0] MAX_VALUE  = 14'd9999;

  // Low seven bits of the active-low common-anode patterns for digits 0..9.
  localparam logic [6:0] SEG_TABLE [10] = '{
    7'h40, 7'h79, 7'h24, 7'h30, 7'h19,
    7'h12, 7'h02, 7'h78, 7'h00, 7'h10
  };

  function automatic logic [6:0] seg_lookup(input bcd_digit_t d);
    logic [6:0] s;
    if (d <= 4'd9) begin
      s = SEG_TABLE[d];
    end else begin
      s = 7'h7F;
    end
    return s;
  endfunction

endpackage

// File: rtl/fnd_bin2bcd_seq.sv
// Iterative shift-add-3 binary to BCD converter. The start edge performs the
// first iteration; done pulses once the last of CONV_STEPS iterations has landed.
module fnd_bin2bcd_seq
  import fnd_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [BIN_W-1:0] bin,
  output logic             done,
  output logic [15:0]      bcd
);

  logic [29:0] shift_r;
  logic [3:0]  steps_r;
  logic        done_r;

  function automatic logic [29:0] dabble_step(input logic [29:0] s);
    logic [29:0] t;
    t = s;
    for (int i = 0; i < 4; i++) begin
      if (t[14 + 4*i +: 4] >= 4'd5) begin
        t[14 + 4*i +: 4] = t[14 + 4*i +: 4] + 4'd3;
      end else begin
        t[14 + 4*i +: 4] = t[14 + 4*i +: 4];
      end
    end
    return {t[28:0], 1'b0};
  endfunction

  // Iteration engine: load plus first step on start, then one step per cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      shift_r <= 30'd0;
      steps_r <= 4'd0;
      done_r  <= 1'b0;
    end else if (start) begin
      shift_r <= dabble_step({16'd0, bin});
      steps_r <= 4'(CONV_STEPS - 1);
      done_r  <= 1'b0;
    end else if (steps_r != 4'd0) begin
      shift_r <= dabble_step(shift_r);
      steps_r <= steps_r - 4'd1;
      done_r  <= (steps_r == 4'd1);
    end else begin
      done_r  <= 1'b0;
    end
  end

  assign done = done_r;
  assign bcd  = shift_r[29:14];

endmodule

// File: rtl/fnd_scan_ctrl.sv
// Four-digit seven-segment scan controller: buffered binary-to-BCD conversion
// with a one-deep pending slot, time-multiplexed commons, blanking and blink.
module fnd_scan_ctrl
  import fnd_pkg::*;
#(
  parameter int unsigned SCAN_DIV    = 100_000,
  parameter int unsigned BLANK_CYC   = 16,
  parameter int unsigned BLINK_SLOTS = 500
) (
  input  logic             PCLK,
  input  logic             PRESET,
  input  logic [BIN_W-1:0] value,
  input  logic             load,
  input  logic [3:0]       digit_en,
  input  logic [3:0]       dp,
  input  logic             lz_en,
  input  logic             blink_en,
  output logic [7:0]       fnd_data,
  output logic [3:0]       fnd_com,
  output logic             busy,
  output logic             sat
);

  localparam int unsigned SLOT_W  = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int unsigned BLINK_W = (BLINK_SLOTS > 1) ? $clog2(BLINK_SLOTS) : 1;
  localparam logic [SLOT_W-1:0]  SLOT_LAST  = SLOT_W'(SCAN_DIV - 1);
  localparam logic [SLOT_W-1:0]  BLANK_END  = SLOT_W'(BLANK_CYC);
  localparam logic [BLINK_W-1:0] BLINK_LAST = BLINK_W'(BLINK_SLOTS - 1);

  conv_state_t          state_r, state_nxt;
  logic                 pend_valid_r;
  logic [BIN_W-1:0]     pend_val_r;
  logic                 conv_sat_r;
  bcd_digit_t [3:0]     digits_r;
  logic                 sat_r;
  logic                 busy_r;

  logic                 start_s;
  logic [BIN_W-1:0]     start_val_s;
  logic                 start_sat_s;
  logic [BIN_W-1:0]     conv_in_s;
  logic                 pend_wr_s;
  logic                 pend_clr_s;
  logic                 commit_s;
  logic                 conv_done_s;
  logic [15:0]          conv_bcd_s;

  logic [SLOT_W-1:0]    slot_cnt_r;
  logic [1:0]           idx_r;
  logic                 slot_wrap_s;
  logic [BLINK_W-1:0]   blink_cnt_r;
  logic                 phase_on_r;

  bcd_digit_t           cur_digit_s;
  logic                 lz_zero_s;
  logic                 blank_s;
  logic [3:0]           com_nxt_s;
  logic [7:0]           data_nxt_s;
  logic [3:0]           fnd_com_r;
  logic [7:0]           fnd_data_r;

  assign start_sat_s = (start_val_s > MAX_VALUE);
  assign conv_in_s   = start_sat_s ? MAX_VALUE : start_val_s;

  fnd_bin2bcd_seq u_bin2bcd (
    .clk   (PCLK),
    .rst   (PRESET),
    .start (start_s),
    .bin   (conv_in_s),
    .done  (conv_done_s),
    .bcd   (conv_bcd_s)
  );

  // Conversion FSM; a load arriving during COMMIT wins over an older pending value.
  always_comb begin
    state_nxt   = state_r;
    start_s     = 1'b0;
    start_val_s = value;
    pend_wr_s   = 1'b0;
    pend_clr_s  = 1'b0;
    commit_s    = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (load) begin
          start_s   = 1'b1;
          state_nxt = ST_CONV;
        end else begin
          state_nxt = ST_IDLE;
        end
      end
      ST_CONV: begin
        pend_wr_s = load;
        if (conv_done_s) begin
          state_nxt = ST_COMMIT;
        end else begin
          state_nxt = ST_CONV;
        end
      end
      ST_COMMIT: begin
        commit_s = 1'b1;
        if (load) begin
          start_s    = 1'b1;
          pend_clr_s = 1'b1;
          state_nxt  = ST_CONV;
        end else if (pend_valid_r) begin
          start_s     = 1'b1;
          start_val_s = pend_val_r;
          pend_clr_s  = 1'b1;
          state_nxt   = ST_CONV;
        end else begin
          state_nxt = ST_IDLE;
        end
      end
      default: begin
        state_nxt = ST_IDLE;
      end
    endcase
  end

  // Conversion state, pending slot and the atomically committed display value.
  always_ff @(posedge PCLK) begin
    if (PRESET) begin
      state_r      <= ST_IDLE;
      pend_valid_r <= 1'b0;
      pend_val_r   <= '0;
      conv_sat_r   <= 1'b0;
      digits_r     <= '0;
      sat_r        <= 1'b0;
      busy_r       <= 1'b0;
    end else begin
      state_r <= state_nxt;
      busy_r  <= (state_nxt != ST_IDLE);
      if (pend_clr_s) begin
        pend_valid_r <= 1'b0;
      end else if (pend_wr_s) begin
        pend_valid_r <= 1'b1;
        pend_val_r   <= value;
      end
      if (start_s) begin
        conv_sat_r <= start_sat_s;
      end
      if (commit_s) begin
        digits_r <= conv_bcd_s;
        sat_r    <= conv_sat_r;
      end
    end
  end

  assign slot_wrap_s = (slot_cnt_r == SLOT_LAST);

  // Slot timer and digit index.
  always_ff @(posedge PCLK) begin
    if (PRESET) begin
      slot_cnt_r <= '0;
      idx_r      <= 2'd0;
    end else if (slot_wrap_s) begin
      slot_cnt_r <= '0;
      idx_r      <= idx_r + 2'd1;
    end else begin
      slot_cnt_r <= slot_cnt_r + SLOT_W'(1);
    end
  end

  // Blink phase advances on slot wraps only while blinking is enabled.
  always_ff @(posedge PCLK) begin
    if (PRESET || !blink_en) begin
      blink_cnt_r <= '0;
      phase_on_r  <= 1'b1;
    end else if (slot_wrap_s) begin
      if (blink_cnt_r == BLINK_LAST) begin
        blink_cnt_r <= '0;
        phase_on_r  <= ~phase_on_r;
      end else begin
        blink_cnt_r <= blink_cnt_r + BLINK_W'(1);
      end
    end else begin
      blink_cnt_r <= blink_cnt_r;
    end
  end

  always_comb begin
    cur_digit_s = digits_r[idx_r];
    lz_zero_s   = 1'b0;
    case (idx_r)
      2'd1:    lz_zero_s = (digits_r[1] == 4'd0) && (digits_r[2] == 4'd0) && (digits_r[3] == 4'd0);
      2'd2:    lz_zero_s = (digits_r[2] == 4'd0) && (digits_r[3] == 4'd0);
      2'd3:    lz_zero_s = (digits_r[3] == 4'd0);
      default: lz_zero_s = 1'b0;
    endcase
    blank_s = (slot_cnt_r < BLANK_END) || !digit_en[idx_r] ||
              (lz_en && lz_zero_s) || (blink_en && !phase_on_r);
    if (blank_s) begin
      com_nxt_s  = 4'hF;
      data_nxt_s = 8'hFF;
    end else begin
      com_nxt_s  = ~(4'b0001 << idx_r);
      data_nxt_s = {~dp[idx_r], seg_lookup(cur_digit_s)};
    end
  end

  // Registered pad drivers.
  always_ff @(posedge PCLK) begin
    if (PRESET) begin
      fnd_com_r  <= 4'hF;
      fnd_data_r <= 8'hFF;
    end else begin
      fnd_com_r  <= com_nxt_s;
      fnd_data_r <= data_nxt_s;
    end
  end

  assign fnd_com  = fnd_com_r;
  assign fnd_data = fnd_data_r;
  assign busy     = busy_r;
  assign sat      = sat_r;

endmodule
